// File: rtl/sram_arbiter_pkg.sv
// Shared constants and types for the two-port SRAM arbiter:
// FSM state encodings, SRAM op encodings, default bus widths and the
// saturating counter helper used by the optional statistics
// (SRAM_ARB_STATS_EN).
package sram_arbiter_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_ACK    = 2'b10
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of requester handshakes, SRAM pins and status for sram_arbiter.
// slave  : arbiter side.
// master : environment side (requesters plus the SRAM read bus).
// SRAM_ARB_STATS_EN adds the per-port grant counters gcnt0/gcnt1.
interface sram_arbiter_if #(
    parameter int DATA_W = sram_arbiter_pkg::DATA_W_DEF,
    parameter int ADDR_W = sram_arbiter_pkg::ADDR_W_DEF
);

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] adr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] adr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic              mem_op;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_in;
    logic [DATA_W-1:0] mem_out;

    logic              busy;

`ifdef SRAM_ARB_STATS_EN
    logic [sram_arbiter_pkg::CNT_W-1:0] gcnt0;
    logic [sram_arbiter_pkg::CNT_W-1:0] gcnt1;

    modport slave (
        input  req0, we0, adr0, wdata0, req1, we1, adr1, wdata1, mem_out,
        output ack0, rdata0, ack1, rdata1,
        output mem_op, mem_sel, mem_adr, mem_in, busy, gcnt0, gcnt1
    );

    modport master (
        output req0, we0, adr0, wdata0, req1, we1, adr1, wdata1, mem_out,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_op, mem_sel, mem_adr, mem_in, busy, gcnt0, gcnt1
    );
`else
    modport slave (
        input  req0, we0, adr0, wdata0, req1, we1, adr1, wdata1, mem_out,
        output ack0, rdata0, ack1, rdata1,
        output mem_op, mem_sel, mem_adr, mem_in, busy
    );

    modport master (
        output req0, we0, adr0, wdata0, req1, we1, adr1, wdata1, mem_out,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_op, mem_sel, mem_adr, mem_in, busy
    );
`endif

endinterface

// File: rtl/sram_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector (rr_pick2).
// A lone request always wins; on a tie the port that was not granted
// last time wins.
module sram_arbiter_rr_pick2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_gnt_valid,
    output logic o_gnt_id
);

    // Pick the winner from the current request pair and grant history.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves it unassigned (no latch).
        o_gnt_valid = i_req0 | i_req1;
        o_gnt_id    = 1'b0;
        if (i_req0 && i_req1) begin
            o_gnt_id = ~i_last_grant;
        end else if (i_req1) begin
            o_gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for an 8x8
// single-port SRAM with combinational read. Each transaction runs
// IDLE (grant) -> ACCESS (mem_sel high one cycle) -> ACK (one-cycle ack).
// Optional: SRAM_ARB_STATS_EN adds saturating per-port completion counters.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  bus
);

    state_t            r_state;
    state_t            w_next_state;

    logic              r_last_grant;
    logic              r_gid;
    logic              r_we;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic              w_grant;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_adr;
    logic [DATA_W-1:0] w_sel_wdata;

    sram_arbiter_rr_pick2 u_rr_pick2 (
        .i_req0       (bus.req0),
        .i_req1       (bus.req1),
        .i_last_grant (r_last_grant),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_id     (w_gnt_id)
    );

    // Requests are only considered while idle; later levels wait their turn.
    assign w_grant     = (r_state == ST_IDLE) && w_gnt_valid;
    assign w_sel_we    = w_gnt_id ? bus.we1    : bus.we0;
    assign w_sel_adr   = w_gnt_id ? bus.adr1   : bus.adr0;
    assign w_sel_wdata = w_gnt_id ? bus.wdata1 : bus.wdata0;

    // State register; reset aborts any access in flight without an ack.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a grant starts a fixed ACCESS, ACK sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_gnt_valid) w_next_state = ST_ACCESS;
            ST_ACCESS: w_next_state = ST_ACK;
            ST_ACK:    w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: select during ACCESS, ack during ACK.
    always_comb begin
        bus.mem_sel = 1'b0;
        bus.mem_op  = OP_READ;
        bus.ack0    = 1'b0;
        bus.ack1    = 1'b0;
        case (r_state)
            ST_ACCESS: begin
                bus.mem_sel = 1'b1;
                bus.mem_op  = r_we;
            end
            ST_ACK: begin
                bus.ack0 = ~r_gid;
                bus.ack1 = r_gid;
            end
            default: ;
        endcase
    end

    // Address and write data stay on the pins between accesses.
    assign bus.mem_adr = r_adr;
    assign bus.mem_in  = r_wdata;
    assign bus.rdata0  = r_rdata0;
    assign bus.rdata1  = r_rdata1;
    assign bus.busy    = (r_state != ST_IDLE);

    // Latch the winning request and update the round-robin history.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: datapath registers are reset as well, since every output must read 0 while in reset.
        if (rst) begin
            r_last_grant <= 1'b1;
            r_gid        <= 1'b0;
            r_we         <= OP_READ;
            r_adr        <= '0;
            r_wdata      <= '0;
        end else if (w_grant) begin
            r_last_grant <= w_gnt_id;
            r_gid        <= w_gnt_id;
            r_we         <= w_sel_we;
            r_adr        <= w_sel_adr;
            r_wdata      <= w_sel_wdata;
        end
    end

    // Capture SRAM read data for the granted port at the edge ending ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (r_state == ST_ACCESS && r_we == OP_READ) begin
            if (r_gid) begin
                r_rdata1 <= bus.mem_out;
            end else begin
                r_rdata0 <= bus.mem_out;
            end
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic [CNT_W-1:0] r_gcnt0;
    logic [CNT_W-1:0] r_gcnt1;

    // Count completed transactions per port, saturating at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gcnt0 <= '0;
            r_gcnt1 <= '0;
        end else if (r_state == ST_ACK) begin
            if (r_gid) begin
                r_gcnt1 <= sat_inc(r_gcnt1);
            end else begin
                r_gcnt0 <= sat_inc(r_gcnt0);
            end
        end
    end

    assign bus.gcnt0 = r_gcnt0;
    assign bus.gcnt1 = r_gcnt1;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter with a behavioural 8x8 SRAM
// (combinational read, write on the clock edge while selected).
// Statistics checks run only when SRAM_ARB_STATS_EN is defined.
module tb_sram_arbiter;

    localparam int DW = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural single-port SRAM.
    logic [DW-1:0] mem [8] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.mem_sel && bus.mem_op) mem[bus.mem_adr] <= bus.mem_in;
    end
    assign bus.mem_out = mem[bus.mem_adr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wd);
        bus.req0 = req; bus.we0 = we; bus.adr0 = adr; bus.wdata0 = wd;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wd);
        bus.req1 = req; bus.we1 = we; bus.adr1 = adr; bus.wdata1 = wd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack0"},    bus.ack0,    1'b0);
        check({tag, "_ack1"},    bus.ack1,    1'b0);
        check({tag, "_mem_sel"}, bus.mem_sel, 1'b0);
        check({tag, "_mem_op"},  bus.mem_op,  1'b0);
        check({tag, "_mem_adr"}, bus.mem_adr, 3'd0);
        check({tag, "_mem_in"},  bus.mem_in,  8'h00);
        check({tag, "_busy"},    bus.busy,    1'b0);
        check({tag, "_rdata0"},  bus.rdata0,  8'h00);
        check({tag, "_rdata1"},  bus.rdata1,  8'h00);
    endtask

    // Watchdog: the run is a fixed number of cycles, so this only fires on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_ack;
        logic exp_port;

        rst = 1'b1;
        drive0(1'b0, 1'b0, 3'd0, 8'h00);
        drive1(1'b0, 1'b0, 3'd0, 8'h00);
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Port 0 writes 0x55 to address 0.
        drive0(1'b1, 1'b1, 3'd0, 8'h55);
        step();
        check("wr0_sel",  bus.mem_sel, 1'b1);
        check("wr0_op",   bus.mem_op,  1'b1);
        check("wr0_adr",  bus.mem_adr, 3'd0);
        check("wr0_in",   bus.mem_in,  8'h55);
        check("wr0_busy", bus.busy,    1'b1);
        check("wr0_noack", bus.ack0,   1'b0);
        step();
        check("wr0_ack0",   bus.ack0,    1'b1);
        check("wr0_ack1",   bus.ack1,    1'b0);
        check("wr0_selack", bus.mem_sel, 1'b0);
        check("wr0_opack",  bus.mem_op,  1'b0);
        check("wr0_inhold", bus.mem_in,  8'h55);
        drive0(1'b0, 1'b0, 3'd0, 8'h00);
        step();
        check("wr0_idle_ack", bus.ack0, 1'b0);
        check("wr0_idle_busy", bus.busy, 1'b0);

        // Port 1 reads address 0 back.
        drive1(1'b1, 1'b0, 3'd0, 8'h00);
        step();
        check("rd1_sel", bus.mem_sel, 1'b1);
        check("rd1_op",  bus.mem_op,  1'b0);
        check("rd1_adr", bus.mem_adr, 3'd0);
        step();
        check("rd1_ack1",  bus.ack1,   1'b1);
        check("rd1_ack0",  bus.ack0,   1'b0);
        check("rd1_data",  bus.rdata1, 8'h55);
        check("rd1_rdata0", bus.rdata0, 8'h00);
        drive1(1'b0, 1'b0, 3'd0, 8'h00);
        step();

        // Tie: both write address 5; port 0 first (last grant was 1).
        drive0(1'b1, 1'b1, 3'd5, 8'hAA);
        drive1(1'b1, 1'b1, 3'd5, 8'h0F);
        step();
        check("tie_adr", bus.mem_adr, 3'd5);
        check("tie_in0", bus.mem_in,  8'hAA);
        step();
        check("tie_ack0", bus.ack0, 1'b1);
        check("tie_ack1", bus.ack1, 1'b0);
        drive0(1'b0, 1'b0, 3'd0, 8'h00);
        step();
        check("tie_idle_sel", bus.mem_sel, 1'b0);
        step();
        check("tie_in1",  bus.mem_in,  8'h0F);
        check("tie_sel1", bus.mem_sel, 1'b1);
        step();
        check("tie_ack1b", bus.ack1, 1'b1);
        check("tie_ack0b", bus.ack0, 1'b0);
        drive1(1'b0, 1'b0, 3'd0, 8'h00);
        step();
        drive0(1'b1, 1'b0, 3'd5, 8'h00);
        step();
        step();
        check("readback_ack0", bus.ack0,   1'b1);
        check("readback_data", bus.rdata0, 8'h0F);
        drive0(1'b0, 1'b0, 3'd0, 8'h00);
        step();

        // Both hold reads for 12 cycles; last grant was 0, so port 1 leads.
        drive0(1'b1, 1'b0, 3'd0, 8'h00);
        drive1(1'b1, 1'b0, 3'd5, 8'h00);
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_ack  = (k % 3 == 2);
            exp_port = ((k / 3) % 2 == 0);
            check($sformatf("rr_ack0_c%0d", k), bus.ack0, exp_ack & ~exp_port);
            check($sformatf("rr_ack1_c%0d", k), bus.ack1, exp_ack &  exp_port);
            check($sformatf("rr_sel_c%0d", k),  bus.mem_sel, (k % 3 == 1));
        end
        drive0(1'b0, 1'b0, 3'd0, 8'h00);
        drive1(1'b0, 1'b0, 3'd0, 8'h00);
        check("rr_rdata0", bus.rdata0, 8'h55);
        check("rr_rdata1", bus.rdata1, 8'h0F);
        step();

        // Reset asserted in the middle of an ACCESS write to address 2.
        drive0(1'b1, 1'b1, 3'd2, 8'h33);
        step();
        check("abort_sel_before", bus.mem_sel, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        drive0(1'b0, 1'b0, 3'd0, 8'h00);
        step();
        check("abort_ack0_edge", bus.ack0, 1'b0);
        check("abort_busy_edge", bus.busy, 1'b0);
        rst = 1'b0;
        step();
        check("abort_idle", bus.busy, 1'b0);

        // After reset a tie goes to port 0; port 1 then sees the unwritten address 2.
        drive0(1'b1, 1'b0, 3'd5, 8'h00);
        drive1(1'b1, 1'b0, 3'd2, 8'h00);
        step();
        check("post_rst_adr0", bus.mem_adr, 3'd5);
        step();
        check("post_rst_ack0", bus.ack0,   1'b1);
        check("post_rst_ack1", bus.ack1,   1'b0);
        check("post_rst_rd0",  bus.rdata0, 8'h0F);
        drive0(1'b0, 1'b0, 3'd0, 8'h00);
        step();
        step();
        check("post_rst_adr1", bus.mem_adr, 3'd2);
        step();
        check("post_rst_ack1b", bus.ack1,   1'b1);
        check("post_rst_rd1",   bus.rdata1, 8'h00);
        drive1(1'b0, 1'b0, 3'd0, 8'h00);
        step();

`ifdef SRAM_ARB_STATS_EN
        check("gcnt0_one", bus.gcnt0, 8'd1);
        check("gcnt1_one", bus.gcnt1, 8'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("gcnt0_clr", bus.gcnt0, 8'd0);
        check("gcnt1_clr", bus.gcnt1, 8'd0);
        for (int i = 0; i < 300; i++) begin
            drive0(1'b1, 1'b1, 3'(i % 8), 8'(i));
            step();
            step();
            drive0(1'b0, 1'b0, 3'd0, 8'h00);
            step();
            if (i == 9) check("gcnt0_ten", bus.gcnt0, 8'd10);
        end
        check("gcnt0_sat", bus.gcnt0, 8'd255);
        check("gcnt1_zero", bus.gcnt1, 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
